// File: rtl/serial_crc5_checker.sv
`default_nettype none
// ============================================================================
//  Module      : serial_crc5_checker
//  Description : Bit-serial codeword checker. Receives DATA_W data bits then
//                CRC_W CRC bits (each MSB first), runs them through a CRC
//                LFSR (init 0, no reflection, no final XOR), and reports the
//                remainder of the whole codeword. A zero remainder means the
//                codeword is consistent.
//  Ports       :
//    clk        in   1       rising-edge clock
//    reset      in   1       synchronous active-high reset
//    start      in   1       begin new codeword, clear previous result
//    bit_valid  in   1       bit_in valid this cycle
//    bit_in     in   1       serial codeword bit
//    data_out   out  DATA_W  received data bits, MSB = first received
//    syndrome   out  CRC_W   LFSR remainder after the full codeword
//    crc_ok     out  1       syndrome == 0 after a completed codeword
//    done       out  1       one-cycle completion pulse
//    busy       out  1       high while codeword bits are accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_crc5_checker #(
  parameter int                DATA_W = 6,
  parameter int                CRC_W  = 5,
  parameter logic [CRC_W-1:0]  POLY   = 5'b00101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_ok,
  output logic              done,
  output logic              busy
);

  localparam int c_max_w = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int c_cnt_w = $clog2(c_max_w + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [CRC_W-1:0]     r_lfsr;
  logic [DATA_W-1:0]    r_data;
  logic [CRC_W-1:0]     r_syndrome;
  logic                 r_crc_ok;

  logic                 w_accept;
  logic                 w_last_data;
  logic                 w_last_crc;
  logic                 w_fb;
  logic [CRC_W-1:0]     w_lfsr_nxt;
  logic                 w_busy;
  logic                 w_done;

  // start always wins over an incoming bit, so a bit presented together
  // with start is dropped.
  assign w_accept    = bit_valid && !start &&
                       ((r_state == S_DATA) || (r_state == S_CRC));
  assign w_last_data = (r_cnt == c_cnt_w'(DATA_W - 1));
  assign w_last_crc  = (r_cnt == c_cnt_w'(CRC_W - 1));

  // Galois-style LFSR step: feedback is the outgoing MSB xor the new bit.
  assign w_fb        = r_lfsr[CRC_W-1] ^ bit_in;
  assign w_lfsr_nxt  = {r_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_busy = 1'b1;
        if (start)                         w_state_nxt = S_DATA;
        else if (bit_valid && w_last_data) w_state_nxt = S_CRC;
      end
      S_CRC: begin
        w_busy = 1'b1;
        if (start)                        w_state_nxt = S_DATA;
        else if (bit_valid && w_last_crc) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = start ? S_DATA : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counter, LFSR, data shift register, result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_lfsr     <= '0;
      r_data     <= '0;
      r_syndrome <= '0;
      r_crc_ok   <= 1'b0;
    end else if (start) begin
      r_cnt      <= '0;
      r_lfsr     <= '0;
      r_data     <= '0;
      r_syndrome <= '0;
      r_crc_ok   <= 1'b0;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_nxt;
      if (r_state == S_DATA) begin
        r_data <= {r_data[DATA_W-2:0], bit_in};
        r_cnt  <= w_last_data ? '0 : r_cnt + 1'b1;
      end else begin
        if (w_last_crc) begin
          // Result is captured on the same edge that enters DONE.
          r_cnt      <= '0;
          r_syndrome <= w_lfsr_nxt;
          r_crc_ok   <= (w_lfsr_nxt == '0);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign data_out = r_data;
  assign syndrome = r_syndrome;
  assign crc_ok   = r_crc_ok;
  assign done     = w_done;
  assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_crc5_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_crc5_checker
//  Description : Directed self-checking bench for serial_crc5_checker.
//                Expected values are hand-computed for poly x^5+x^2+1:
//                  CRC(101011)             = 10011
//                  syndrome(001011_10011)  = 11111
//                  CRC(000000)             = 00000
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_crc5_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic       bit_valid;
  logic       bit_in;
  logic [5:0] data_out;
  logic [4:0] syndrome;
  logic       crc_ok;
  logic       done;
  logic       busy;

  int n_checks;
  int n_fail;
  int done_cnt;

  serial_crc5_checker #(
    .DATA_W (6),
    .CRC_W  (5),
    .POLY   (5'b00101)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .data_out  (data_out),
    .syndrome  (syndrome),
    .crc_ok    (crc_ok),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the current inputs; returns 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Sends the codeword MSB first, count bits taken from the top of w.
  task automatic send_bits(input logic [10:0] w, input int count);
    for (int i = 10; i > 10 - count; i--) begin
      send_bit(w[i]);
    end
  endtask

  task automatic check_result(input string name, input logic [5:0] exp_data,
                              input logic [4:0] exp_syn, input logic exp_ok);
    check_eq({name, "_done"},     {31'd0, done},     32'd1);
    check_eq({name, "_busy"},     {31'd0, busy},     32'd0);
    check_eq({name, "_data"},     {26'd0, data_out}, {26'd0, exp_data});
    check_eq({name, "_syndrome"}, {27'd0, syndrome}, {27'd0, exp_syn});
    check_eq({name, "_crc_ok"},   {31'd0, crc_ok},   {31'd0, exp_ok});
  endtask

  initial begin
    logic bad;
    n_checks  = 0;
    n_fail    = 0;
    done_cnt  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_busy",     {31'd0, busy},     32'd0);
    check_eq("rst_done",     {31'd0, done},     32'd0);
    check_eq("rst_data",     {26'd0, data_out}, 32'd0);
    check_eq("rst_syndrome", {27'd0, syndrome}, 32'd0);
    check_eq("rst_crc_ok",   {31'd0, crc_ok},   32'd0);
    reset = 1'b0;
    tick();

    // Good codeword 101011_10011
    done_cnt = 0;
    do_start();
    check_eq("a_busy_after_start", {31'd0, busy}, 32'd1);
    send_bits(11'b101011_10011, 10);
    check_eq("a_done_before_last", {31'd0, done}, 32'd0);
    check_eq("a_busy_before_last", {31'd0, busy}, 32'd1);
    send_bit(1'b1);
    check_result("a", 6'b101011, 5'b00000, 1'b1);
    tick();
    check_eq("a_done_one_cycle", {31'd0, done},   32'd0);
    check_eq("a_crc_ok_hold",    {31'd0, crc_ok}, 32'd1);
    tick();
    check_eq("a_done_count", done_cnt, 32'd1);

    // Data MSB flipped: 001011_10011
    done_cnt = 0;
    do_start();
    check_eq("b_crc_ok_cleared", {31'd0, crc_ok}, 32'd0);
    send_bits(11'b001011_10011, 11);
    check_result("b", 6'b001011, 5'b11111, 1'b0);
    tick();
    tick();
    check_eq("b_done_count",    done_cnt,          32'd1);
    check_eq("b_syndrome_hold", {27'd0, syndrome}, {27'd0, 5'b11111});

    // All zeros with bit_valid low on alternate cycles
    done_cnt = 0;
    do_start();
    bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (!busy || done) bad = 1'b1;
      send_bit(1'b0);
      if (i < 10) begin
        if (!busy || done) bad = 1'b1;
        tick();
      end
    end
    check_eq("c_busy_done_during_word", {31'd0, bad}, 32'd0);
    check_result("c", 6'b000000, 5'b00000, 1'b1);
    tick();
    tick();
    check_eq("c_done_count", done_cnt, 32'd1);

    // Abandoned word, restart with a simultaneous (discarded) bit
    done_cnt = 0;
    do_start();
    send_bits(11'b1010_0000000, 4);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check_eq("d_data_cleared", {26'd0, data_out}, 32'd0);
    send_bits(11'b101011_10011, 11);
    check_result("d", 6'b101011, 5'b00000, 1'b1);
    tick();
    tick();
    check_eq("d_done_count", done_cnt, 32'd1);

    // Reset after 7 accepted bits
    done_cnt = 0;
    do_start();
    send_bits(11'b101011_10011, 7);
    check_eq("e_data_before_rst", {26'd0, data_out}, {26'd0, 6'b101011});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("e_busy",     {31'd0, busy},     32'd0);
    check_eq("e_done",     {31'd0, done},     32'd0);
    check_eq("e_data",     {26'd0, data_out}, 32'd0);
    check_eq("e_syndrome", {27'd0, syndrome}, 32'd0);
    check_eq("e_crc_ok",   {31'd0, crc_ok},   32'd0);
    send_bits(11'b1111_0000000, 4);
    tick();
    check_eq("e_done_count", done_cnt, 32'd0);

    // bit_valid pulses in IDLE without start
    done_cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      if (busy || done || crc_ok || (data_out != 6'd0)) bad = 1'b1;
      tick();
    end
    check_eq("f_idle_ignores_bits", {31'd0, bad},      32'd0);
    check_eq("f_data",              {26'd0, data_out}, 32'd0);
    check_eq("f_done_count",        done_cnt,          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
